id_ex_reg: RTL and testbench
============================

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-003 StallE  input  1  hold: all E outputs keep current values.
REQ-004 FlushE  input  1  bubble: E stage loaded with a NOP.
REQ-005 ValidD / ValidE  input / output  1  decode slot holds a real instruction / execute slot holds a real instruction.
REQ-006 RegWriteD / RegWriteE  input / output  1  register-file write enable.
REQ-007 ResultSrcD / ResultSrcE  input / output  2  writeback mux select.
REQ-008 MemWriteD / MemWriteE  input / output  1  data-memory write enable.
REQ-009 JumpD / JumpE  input / output  1  jal/jalr.
REQ-010 BranchD / BranchE  input / output  1  conditional branch.
REQ-011 ALUControlD / ALUControlE  input / output  3  ALU operation code from the decode-stage ALU controller (000 add, 001 sub, 010 and, 011 or, 101 slt).
REQ-012 ALUSrcD / ALUSrcE  input / output  1  ALU B operand select (0 register, 1 immediate).
REQ-013 funct3D / funct3E  input / output  3  branch-type select (000 beq, 001 bne).
REQ-014 RD1D, RD2D / RD1E, RD2E  input / output  32 each  register-file read data.
REQ-015 PCD, PCPlus4D, ImmExtD / PCE, PCPlus4E, ImmExtE  input / output  32 each  PC, PC+4, extended immediate.
REQ-016 Rs1D, Rs2D, RdD / Rs1E, Rs2E, RdE  input / output  5 each  register addresses for hazard unit and writeback.

Function
REQ-017 The block SHALL be a single-stage register: with StallE=0 and FlushE=0, every E output SHALL equal its D input from the previous rising edge (latency exactly 1 cycle).
REQ-018 With StallE=1 and FlushE=0, all E outputs (including ValidE) SHALL hold their values for that edge.
REQ-019 With FlushE=1, on the edge, all E outputs SHALL be loaded with zero regardless of StallE (flush has priority over stall).
REQ-020 A zero-loaded slot SHALL be a NOP: RegWriteE=0, MemWriteE=0, JumpE=0, BranchE=0, ValidE=0, ALUControlE=000.
REQ-021 ValidE SHALL be ValidD captured under the same stall/flush rules; when ValidD=0 on a normal load, all control outputs (RegWrite, MemWrite, Jump, Branch) SHALL be loaded as 0 while data fields load normally.
REQ-022 ALUControlE SHALL be passed through unmodified; the block SHALL NOT decode or re-encode it; unused codes (100, 110, 111) SHALL propagate unchanged.
REQ-023 No combinational path SHALL exist from any input to any output.
REQ-024 Consecutive stall cycles of any length SHALL hold state indefinitely; the first non-stall edge SHALL load the D inputs present at that edge.

Reset
REQ-025 While rst=0, all outputs SHALL be zero (NOP slot, ValidE=0) immediately, independent of clk.
REQ-026 Reset deassertion mid-stall or mid-flush SHALL leave outputs at zero until the next rising edge, which SHALL then apply REQ-017..REQ-021 normally.

Configuration
REQ-027 Macro ID_EX_TRACE_EN SHALL, when defined, add InstrD (input, 32) / InstrE (output, 32) following REQ-017..REQ-019, plus BubbleCountE (output, 16): increments by 1 on each edge where FlushE=1 or a NOP (ValidE=0 after the edge) is loaded, saturates at 16'hFFFF, holds during stall, cleared by reset.
REQ-028 Without ID_EX_TRACE_EN, InstrD, InstrE and BubbleCountE SHALL not exist and the remaining behaviour SHALL be identical.

Verification
REQ-029 Reset: rst=0 with random D inputs and clocks running -> all E outputs 0, ValidE=0; release rst -> next edge loads D.
REQ-030 Pass-through: ValidD=1, ALUControlD=001, RegWriteD=1, RD1D=32'h0000_0005, RdD=5'd7 -> one edge later ALUControlE=001, RegWriteE=1, RD1E=32'h5, RdE=7.
REQ-031 Stall: load PCD=32'h100, then StallE=1 for 3 edges with PCD=32'h104 -> PCE stays 32'h100; StallE=0 -> PCE=32'h104 next edge.
REQ-032 Stall+flush same edge: StallE=1, FlushE=1, RegWriteE=1 beforehand -> after edge RegWriteE=0, ValidE=0, ALUControlE=000.
REQ-033 Invalid decode: ValidD=0, MemWriteD=1, ImmExtD=32'hFFFF_FFF0 -> MemWriteE=0, ValidE=0, ImmExtE=32'hFFFF_FFF0.
REQ-034 Trace (ID_EX_TRACE_EN): force BubbleCountE to 16'hFFFE via 65534 flushes, 2 more flushes -> BubbleCountE=16'hFFFF, no wrap.

Source files
------------

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: a single stage with stall (hold), flush (NOP bubble) and async active-low reset.
// Optional ID_EX_TRACE_EN adds the InstrD/InstrE passthrough and a saturating BubbleCountE counter.
module id_ex_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallE,
  input  logic        FlushE,
  input  logic        ValidD,
  input  logic        RegWriteD,
  input  logic [1:0]  ResultSrcD,
  input  logic        MemWriteD,
  input  logic        JumpD,
  input  logic        BranchD,
  input  logic [2:0]  ALUControlD,
  input  logic        ALUSrcD,
  input  logic [2:0]  funct3D,
  input  logic [31:0] RD1D,
  input  logic [31:0] RD2D,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic [31:0] ImmExtD,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  RdD,
`ifdef ID_EX_TRACE_EN
  input  logic [31:0] InstrD,
  output logic [31:0] InstrE,
  output logic [15:0] BubbleCountE,
`endif
  output logic        ValidE,
  output logic        RegWriteE,
  output logic [1:0]  ResultSrcE,
  output logic        MemWriteE,
  output logic        JumpE,
  output logic        BranchE,
  output logic [2:0]  ALUControlE,
  output logic        ALUSrcE,
  output logic [2:0]  funct3E,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E,
  output logic [31:0] ImmExtE,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [4:0]  RdE
);

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [1:0]  result_src;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic [2:0]  alu_control;
    logic        alu_src;
    logic [2:0]  funct3;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] imm_ext;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
`ifdef ID_EX_TRACE_EN
    logic [31:0] instr;
`endif
  } ex_slot_t;

  ex_slot_t slot_d, slot_q;

  // Side-effecting controls are gated by ValidD so an invalid slot can never write or redirect.
  always_comb begin
    slot_d             = '0;
    slot_d.valid       = ValidD;
    slot_d.reg_write   = RegWriteD & ValidD;
    slot_d.result_src  = ResultSrcD;
    slot_d.mem_write   = MemWriteD & ValidD;
    slot_d.jump        = JumpD & ValidD;
    slot_d.branch      = BranchD & ValidD;
    slot_d.alu_control = ALUControlD;
    slot_d.alu_src     = ALUSrcD;
    slot_d.funct3      = funct3D;
    slot_d.rd1         = RD1D;
    slot_d.rd2         = RD2D;
    slot_d.pc          = PCD;
    slot_d.pc_plus4    = PCPlus4D;
    slot_d.imm_ext     = ImmExtD;
    slot_d.rs1         = Rs1D;
    slot_d.rs2         = Rs2D;
    slot_d.rd          = RdD;
`ifdef ID_EX_TRACE_EN
    slot_d.instr       = InstrD;
`endif
  end

  // Flush wins over stall; an all-zero slot is the NOP encoding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         slot_q <= '0;
    else if (FlushE)  slot_q <= '0;
    else if (!StallE) slot_q <= slot_d;
  end

  assign ValidE      = slot_q.valid;
  assign RegWriteE   = slot_q.reg_write;
  assign ResultSrcE  = slot_q.result_src;
  assign MemWriteE   = slot_q.mem_write;
  assign JumpE       = slot_q.jump;
  assign BranchE     = slot_q.branch;
  assign ALUControlE = slot_q.alu_control;
  assign ALUSrcE     = slot_q.alu_src;
  assign funct3E     = slot_q.funct3;
  assign RD1E        = slot_q.rd1;
  assign RD2E        = slot_q.rd2;
  assign PCE         = slot_q.pc;
  assign PCPlus4E    = slot_q.pc_plus4;
  assign ImmExtE     = slot_q.imm_ext;
  assign Rs1E        = slot_q.rs1;
  assign Rs2E        = slot_q.rs2;
  assign RdE         = slot_q.rd;

`ifdef ID_EX_TRACE_EN
  logic [15:0] bubble_q;
  logic        bubble_evt;

  // A bubble is a flush, or a non-stalled load of an invalid decode slot.
  assign bubble_evt = FlushE | (~StallE & ~ValidD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  bubble_q <= '0;
    else if (bubble_evt && bubble_q != 16'hFFFF) bubble_q <= bubble_q + 16'd1;
  end

  assign InstrE       = slot_q.instr;
  assign BubbleCountE = bubble_q;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed self-checking bench for id_ex_reg: reset, pass-through, stall, flush, invalid decode.
module tb_id_ex_reg;
  logic        clk, rst, StallE, FlushE;
  logic        ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0]  ResultSrcD;
  logic [2:0]  ALUControlD, funct3D;
  logic [31:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic        ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE, funct3E;
  logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
  logic [4:0]  Rs1E, Rs2E, RdE;
`ifdef ID_EX_TRACE_EN
  logic [31:0] InstrD, InstrE;
  logic [15:0] BubbleCountE;
`endif

  int vectors = 0;
  int miscompares = 0;

  id_ex_reg dut (
    .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE),
    .ValidD(ValidD), .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD),
    .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
    .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD), .funct3D(funct3D),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
`ifdef ID_EX_TRACE_EN
    .InstrD(InstrD), .InstrE(InstrE), .BubbleCountE(BubbleCountE),
`endif
    .ValidE(ValidE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
    .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .funct3E(funct3E),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Any bit set anywhere in the E slot.
  logic any_e;
  assign any_e = |{ValidE, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE,
                   ALUSrcE, funct3E, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_d();
    ValidD = 1'($urandom); RegWriteD = 1'($urandom); MemWriteD = 1'($urandom);
    JumpD = 1'($urandom); BranchD = 1'($urandom); ALUSrcD = 1'($urandom);
    ResultSrcD = 2'($urandom); ALUControlD = 3'($urandom); funct3D = 3'($urandom);
    RD1D = $urandom; RD2D = $urandom; PCD = $urandom; PCPlus4D = $urandom; ImmExtD = $urandom;
    Rs1D = 5'($urandom); Rs2D = 5'($urandom); RdD = 5'($urandom);
`ifdef ID_EX_TRACE_EN
    InstrD = $urandom;
`endif
  endtask

  task automatic clear_d();
    ValidD = 0; RegWriteD = 0; MemWriteD = 0; JumpD = 0; BranchD = 0; ALUSrcD = 0;
    ResultSrcD = 0; ALUControlD = 0; funct3D = 0;
    RD1D = 0; RD2D = 0; PCD = 0; PCPlus4D = 0; ImmExtD = 0; Rs1D = 0; Rs2D = 0; RdD = 0;
`ifdef ID_EX_TRACE_EN
    InstrD = 0;
`endif
  endtask

  initial begin
    rst = 1'b0; StallE = 0; FlushE = 0;
    rand_d();
    ValidD = 1; RegWriteD = 1;
    // Reset held with clocks running and random inputs.
    step(); rand_d(); ValidD = 1; step(); step();
    check("rst_all_zero", 32'(any_e), 32'd0);
    check("rst_valid", 32'(ValidE), 32'd0);

    // Release reset; first edge loads D.
    clear_d(); ValidD = 1; PCD = 32'hCAFE_0000; RdD = 5'd3;
    #2 rst = 1'b1;
    check("rst_rel_pre_edge", 32'(any_e), 32'd0);
    step();
    check("rst_rel_pc", PCE, 32'hCAFE_0000);
    check("rst_rel_valid", 32'(ValidE), 32'd1);

    // Pass-through.
    clear_d(); ValidD = 1; ALUControlD = 3'b001; RegWriteD = 1; RD1D = 32'h5; RdD = 5'd7;
    ResultSrcD = 2'b10; funct3D = 3'b001; Rs1D = 5'd9; Rs2D = 5'd31; PCPlus4D = 32'h44;
    step();
    check("pt_alu", 32'(ALUControlE), 32'd1);
    check("pt_regwrite", 32'(RegWriteE), 32'd1);
    check("pt_rd1", RD1E, 32'h5);
    check("pt_rd", 32'(RdE), 32'd7);
    check("pt_resultsrc", 32'(ResultSrcE), 32'd2);
    check("pt_rs_pair", {22'd0, Rs1E, Rs2E}, {22'd0, 5'd9, 5'd31});
    check("pt_pcplus4", PCPlus4E, 32'h44);

    // Unused ALU code propagates untouched.
    ALUControlD = 3'b111; step();
    check("pt_alu_111", 32'(ALUControlE), 32'd7);

    // Stall holds for three edges, then the D present at the release edge loads.
    clear_d(); ValidD = 1; PCD = 32'h100; step();
    check("stall_load", PCE, 32'h100);
    StallE = 1; PCD = 32'h104; ValidD = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold_pc", PCE, 32'h100);
    end
    check("stall_hold_valid", 32'(ValidE), 32'd1);
    StallE = 0; ValidD = 1; step();
    check("stall_release_pc", PCE, 32'h104);

    // Stall and flush on the same edge: flush wins.
    clear_d(); ValidD = 1; RegWriteD = 1; ALUControlD = 3'b011; PCD = 32'h200; step();
    check("sf_pre_regwrite", 32'(RegWriteE), 32'd1);
    StallE = 1; FlushE = 1; step();
    check("sf_regwrite", 32'(RegWriteE), 32'd0);
    check("sf_valid", 32'(ValidE), 32'd0);
    check("sf_alu", 32'(ALUControlE), 32'd0);
    check("sf_all_zero", 32'(any_e), 32'd0);
    StallE = 0; FlushE = 0;

    // Invalid decode: controls squashed, data fields load.
    clear_d(); ValidD = 0; MemWriteD = 1; RegWriteD = 1; JumpD = 1; BranchD = 1;
    ImmExtD = 32'hFFFF_FFF0; ALUControlD = 3'b101; RD2D = 32'h1234_5678;
    step();
    check("inv_memwrite", 32'(MemWriteE), 32'd0);
    check("inv_valid", 32'(ValidE), 32'd0);
    check("inv_ctrl", {28'd0, RegWriteE, MemWriteE, JumpE, BranchE}, 32'd0);
    check("inv_imm", ImmExtE, 32'hFFFF_FFF0);
    check("inv_rd2", RD2E, 32'h1234_5678);
    check("inv_alu", 32'(ALUControlE), 32'd5);

    // Async reset mid-cycle, then release mid-stall.
    clear_d(); ValidD = 1; JumpD = 1; PCD = 32'h300; step();
    check("ar_pre_jump", 32'(JumpE), 32'd1);
    #2 rst = 1'b0; #1;
    check("ar_async_zero", 32'(any_e), 32'd0);
    StallE = 1; PCD = 32'h304;
    #1 rst = 1'b1; #1;
    check("ar_release_zero", 32'(any_e), 32'd0);
    step();
    check("ar_stall_edge_zero", 32'(any_e), 32'd0);
    StallE = 0; step();
    check("ar_load_pc", PCE, 32'h304);
    check("ar_load_jump", 32'(JumpE), 32'd1);

`ifdef ID_EX_TRACE_EN
    // Trace counter: reset clears, flushes count, saturates without wrap.
    rst = 1'b0; #1; rst = 1'b1;
    check("tr_rst_count", 32'(BubbleCountE), 32'd0);
    clear_d(); ValidD = 1; InstrD = 32'h0000_0013; step();
    check("tr_instr", InstrE, 32'h0000_0013);
    check("tr_valid_no_bump", 32'(BubbleCountE), 32'd0);
    StallE = 1; ValidD = 0; step();
    check("tr_stall_hold", 32'(BubbleCountE), 32'd0);
    check("tr_instr_hold", InstrE, 32'h0000_0013);
    StallE = 0; FlushE = 1;
    for (int i = 0; i < 65534; i++) @(posedge clk);
    #1;
    check("tr_fffe", 32'(BubbleCountE), 32'h0000_FFFE);
    check("tr_instr_flushed", InstrE, 32'd0);
    step(); step();
    check("tr_saturate", 32'(BubbleCountE), 32'h0000_FFFF);
    FlushE = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
